stream_demux_8: RTL
===================

Name: stream_demux_8

Overview:
- 1-to-2 demultiplexer for the 8-bit capture sample stream. It is the inverse of the 2:1 byte mux that merges sources.
- Steers a valid/ready byte stream to output A or output B. The selection is locked per packet, so a packet is never split across outputs.
- Each output has a one-entry registered stage, and each output has a saturating beat counter.
- Sits between the sample formatter and the two downstream consumers (trigger engine and capture buffer writer).

Parameters:
- DATA_W, 8, width of the data bus.
- CNT_W, 16, width of each per-output beat counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sel  in  1  destination select: 1 = A, 0 = B (same polarity as the merging mux). Sampled only at packet start.
- s_data  in  DATA_W  input byte.
- s_valid  in  1  input beat valid.
- s_last  in  1  final beat of the packet.
- s_ready  out  1  input accept.
- a_data  out  DATA_W  output A byte.
- a_valid  out  1  output A beat valid.
- a_last  out  1  output A end of packet.
- a_ready  in  1  output A accept.
- b_data  out  DATA_W  output B byte.
- b_valid  out  1  output B beat valid.
- b_last  out  1  output B end of packet.
- b_ready  in  1  output B accept.
- clr_cnt  in  1  synchronous clear of both counters.
- cnt_a  out  CNT_W  beats delivered on A (saturating).
- cnt_b  out  CNT_W  beats delivered on B (saturating).
- busy  out  1  high while a packet is open or either output stage holds data.

Behaviour:
- Reset (async assert, sync release) values:
  - State = IDLE.
  - a_valid, b_valid, a_last, b_last = 0.
  - a_data, b_data = 0.
  - cnt_a, cnt_b = 0.
  - busy = 0.
  - s_ready follows the stage rules below, so it is 1 once reset is released.
- State machine:
  - IDLE: route = sel (combinational).
  - IDLE -> LOCK_A when a beat is accepted with sel=1 and s_last=0.
  - IDLE -> LOCK_B when a beat is accepted with sel=0 and s_last=0.
  - A single-beat packet (s_last=1 in IDLE) is routed by sel and the state stays IDLE.
  - LOCK_A / LOCK_B: route is fixed to A / B and sel is ignored. Return to IDLE on the accepted beat with s_last=1.
- Output stage per port, a one-entry pipeline register:
  - stage_ready = !x_valid || x_ready.
  - s_ready = stage_ready of the currently routed output.
  - Input transfer when s_valid && s_ready. That cycle loads data and last into the routed stage and sets its valid.
  - Output transfer when x_valid && x_ready. This clears valid unless a new beat loads in the same cycle, in which case valid stays 1.
- Latency: an accepted beat appears on the output on the next cycle. Full throughput is 1 beat/cycle while the downstream holds ready=1.
- The non-routed output is unaffected. It may still drain its held beat in parallel.
- No combinational path from s_valid to x_valid. The only combinational path from x_ready is to s_ready.
- Output x_data and x_last hold stable while x_valid=1 && x_ready=0.
- Counters:
  - Increment on each output-side transfer.
  - Saturate at all-ones.
  - clr_cnt has priority over an increment in the same cycle, giving 0.
- busy = (state != IDLE) || a_valid || b_valid.
- Boundary conditions:
  - sel toggling mid-packet: no effect.
  - s_valid=1 while the routed stage is full and its downstream is stalled: s_ready=0. The beat is held by the source; nothing is dropped or duplicated.
  - Simultaneous input load and output drain on the same stage: both occur.
  - Reset mid-packet: stage contents are discarded and the FSM returns to IDLE. The next beat after reset is treated as a packet start.

Decomposition:
- Package la_stream_pkg holds:
  - typedef of the state enum {IDLE, LOCK_A, LOCK_B};
  - constant SEL_A = 1'b1;
  - the shared byte typedef.
- One natural sub-module, stream_reg_slice: the one-entry valid/ready register with data+last. It is instantiated twice. The counters and FSM stay in the top module.

Test Plan:
- Single-beat routing:
  - Stimulus: sel=1, packet 0x11,0x22,0x33 (last on 0x33), both readies high.
  - Response: a_data sequence 0x11,0x22,0x33 on consecutive cycles, each one cycle after acceptance; a_last only on 0x33; b_valid stays 0; cnt_a=3.
- Packet lock:
  - Stimulus: sel=0 at the first beat 0xA0, sel toggled to 1 on beats 2–4, 4-beat packet.
  - Response: all 4 beats on B, cnt_b=4, cnt_a=0. The next packet with sel=1 goes to A.
- Backpressure:
  - Stimulus: routed to A, a_ready=0 for 5 cycles during a stream of 0x01..0x06.
  - Response: s_ready=0 after one beat is held, and a_data=0x01 stays stable while stalled. After a_ready=1, output order is exactly 0x01..0x06 with no loss or duplication.
- Parallel drain:
  - Stimulus: B holds a beat with b_ready=0; a new packet with sel=1 is routed to A.
  - Response: A streams at full rate while B still holds its beat, unaffected.
- Counter saturation and clear:
  - Stimulus: CNT_W=4, then 20 beats to A.
  - Response: cnt_a=15. A clr_cnt pulse coincident with a transfer gives cnt_a=0.
- Reset mid-packet:
  - Stimulus: assert rst_n=0 after 2 beats of a 5-beat packet to B.
  - Response: b_valid=0, cnt_b=0 and busy=0 immediately (async). After release, a new packet with sel=1 routes to A.

Source files
------------

// File: rtl/la_stream_pkg.sv
// Shared types for the capture-stream blocks.
// Holds the demux state encoding, the select polarity and the byte type.
package la_stream_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        LOCK_A,
        LOCK_B
    } state_t;

    // Same polarity as the 2:1 merging mux upstream.
    localparam logic SEL_A = 1'b1;

endpackage

// File: rtl/stream_reg_slice.sv
// One-entry valid/ready register slice carrying data and last.
// Latency: 1 cycle. Backpressure: ready = empty or downstream ready, so full rate with no bubbles.
module stream_reg_slice #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready
);

    assign s_ready = !m_valid || m_ready;

    // A load in the same cycle as a drain keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data  <= '0;
            m_last  <= 1'b0;
            m_valid <= 1'b0;
        end else if (s_valid && s_ready) begin
            m_data  <= s_data;
            m_last  <= s_last;
            m_valid <= 1'b1;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux_8.sv
// 1-to-2 packet-locked byte stream demux with a registered stage per output and saturating beat counters.
// Latency: 1 cycle input to output. Backpressure: s_ready is the routed stage's ready; the other output drains independently.
module stream_demux_8
    import la_stream_pkg::*;
#(
    parameter int DATA_W = BYTE_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [DATA_W-1:0] a_data,
    output logic              a_valid,
    output logic              a_last,
    input  logic              a_ready,
    output logic [DATA_W-1:0] b_data,
    output logic              b_valid,
    output logic              b_last,
    input  logic              b_ready,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt_a,
    output logic [CNT_W-1:0]  cnt_b,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state;
    logic   route_a;
    logic   a_stage_rdy;
    logic   b_stage_rdy;
    logic   accept;

    // sel only matters at a packet boundary; inside a packet the route is locked.
    always_comb begin
        route_a = (sel == SEL_A);
        case (state)
            LOCK_A:  route_a = 1'b1;
            LOCK_B:  route_a = 1'b0;
            default: route_a = (sel == SEL_A);
        endcase
    end

    assign s_ready = route_a ? a_stage_rdy : b_stage_rdy;
    assign accept  = s_valid && s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (accept) begin
            if (s_last)
                state <= IDLE;
            else if (state == IDLE)
                state <= route_a ? LOCK_A : LOCK_B;
        end
    end

    stream_reg_slice #(.DATA_W(DATA_W)) u_slice_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (s_data),
        .s_valid (s_valid && route_a),
        .s_last  (s_last),
        .s_ready (a_stage_rdy),
        .m_data  (a_data),
        .m_valid (a_valid),
        .m_last  (a_last),
        .m_ready (a_ready)
    );

    stream_reg_slice #(.DATA_W(DATA_W)) u_slice_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (s_data),
        .s_valid (s_valid && !route_a),
        .s_last  (s_last),
        .s_ready (b_stage_rdy),
        .m_data  (b_data),
        .m_valid (b_valid),
        .m_last  (b_last),
        .m_ready (b_ready)
    );

    // Clear wins over a same-cycle delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (clr_cnt) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (a_valid && a_ready && cnt_a != CNT_MAX)
                cnt_a <= cnt_a + CNT_ONE;
            if (b_valid && b_ready && cnt_b != CNT_MAX)
                cnt_b <= cnt_b + CNT_ONE;
        end
    end

    assign busy = (state != IDLE) || a_valid || b_valid;

endmodule
